mcdt_arbiter: RTL

- Output-side scheduler for the multi-channel data transfer (mcdt) path.
- Takes the non-empty/data views of the three channel FIFOs (ch0..ch2) and decides which channel pops one word per cycle.
- Forwards the popped word, registered, as mcdt_data_o / mcdt_val_o / mcdt_id_o.
- Supports round-robin with a configurable burst hold, or fixed priority, plus per-channel enable.

---
 rtl/mcdt_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mcdt_arbiter.sv
// mcdt_arbiter: output-side scheduler for the multi-channel data transfer path.
// Picks at most one of three channel FIFOs to pop per cycle and forwards the
// popped word one cycle later.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   chN_req_i             chN FIFO non-empty
//   chN_data_i            chN FIFO head word
//   chN_ack_o             chN FIFO pop strobe (combinational)
//   ch_en_i[2:0]          per-channel enable, bit n = chN
//   prio_mode_i           0 = round-robin with burst hold, 1 = fixed priority ch0>ch1>ch2
//   mcdt_data_o           forwarded word (zero on idle cycles)
//   mcdt_val_o            forwarded word valid
//   mcdt_id_o             source channel of the forwarded word (holds when idle)
module mcdt_arbiter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ch0_req_i,
  input  logic [DW-1:0] ch0_data_i,
  output logic          ch0_ack_o,
  input  logic          ch1_req_i,
  input  logic [DW-1:0] ch1_data_i,
  output logic          ch1_ack_o,
  input  logic          ch2_req_i,
  input  logic [DW-1:0] ch2_data_i,
  output logic          ch2_ack_o,
  input  logic [2:0]    ch_en_i,
  input  logic          prio_mode_i,
  output logic [DW-1:0] mcdt_data_o,
  output logic          mcdt_val_o,
  output logic [1:0]    mcdt_id_o
);

  localparam logic [3:0] BurstMax = 4'(BURST);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;

  // Bit 3 pads the vector so any 2-bit index is in range.
  logic [3:0] elig;
  assign elig = {1'b0, ch2_req_i & ch_en_i[2], ch1_req_i & ch_en_i[1], ch0_req_i & ch_en_i[0]};

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Round-robin search starting after the pointer; the pointer itself comes last.
  logic [1:0] rr_c1, rr_c2;
  logic       rr_vld;
  logic [1:0] rr_id;

  always_comb begin
    rr_c1  = next_ch(ptr_q);
    rr_c2  = next_ch(rr_c1);
    rr_vld = 1'b1;
    rr_id  = ptr_q;
    if (elig[rr_c1])      rr_id = rr_c1;
    else if (elig[rr_c2]) rr_id = rr_c2;
    else if (elig[ptr_q]) rr_id = ptr_q;
    else                  rr_vld = 1'b0;
  end

  logic       gnt_vld;
  logic [1:0] gnt_id;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_vld = 1'b0;
    gnt_id  = 2'd0;

    if (prio_mode_i) begin
      // Fixed priority keeps no burst state; a later switch to RR starts from IDLE.
      state_d = StIdle;
      cnt_d   = 4'd0;
      if (elig[0]) begin
        gnt_vld = 1'b1;
        gnt_id  = 2'd0;
      end else if (elig[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = 2'd1;
      end else if (elig[2]) begin
        gnt_vld = 1'b1;
        gnt_id  = 2'd2;
      end
      if (gnt_vld) ptr_d = gnt_id;
    end else if (state_q == StGrant && elig[owner_q] && cnt_q < BurstMax) begin
      gnt_vld = 1'b1;
      gnt_id  = owner_q;
      cnt_d   = cnt_q + 4'd1;
    end else if (rr_vld) begin
      // Covers IDLE and burst end; in GRANT the pointer equals the owner.
      gnt_vld = 1'b1;
      gnt_id  = rr_id;
      state_d = StGrant;
      owner_d = rr_id;
      cnt_d   = 4'd1;
      ptr_d   = rr_id;
    end else begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd2;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ch0_ack_o = gnt_vld & (gnt_id == 2'd0) & ~rst_i;
  assign ch1_ack_o = gnt_vld & (gnt_id == 2'd1) & ~rst_i;
  assign ch2_ack_o = gnt_vld & (gnt_id == 2'd2) & ~rst_i;

  logic [DW-1:0] gnt_data;

  always_comb begin
    gnt_data = '0;
    unique case (gnt_id)
      2'd0:    gnt_data = ch0_data_i;
      2'd1:    gnt_data = ch1_data_i;
      2'd2:    gnt_data = ch2_data_i;
      default: gnt_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcdt_data_o <= '0;
      mcdt_val_o  <= 1'b0;
      mcdt_id_o   <= 2'd0;
    end else if (gnt_vld) begin
      mcdt_data_o <= gnt_data;
      mcdt_val_o  <= 1'b1;
      mcdt_id_o   <= gnt_id;
    end else begin
      mcdt_data_o <= '0;
      mcdt_val_o  <= 1'b0;
    end
  end

endmodule
